// File: rtl/wdata_order_queue_pkg.sv
// Shared widths for the write-data ordering queue and its entry FIFO.
// The entry struct itself is declared in the top, where ID_W and LEN_W are known.
package wdata_order_queue_pkg;

    function automatic int id_w(input int num_masters);
        return (num_masters > 1) ? $clog2(num_masters) : 1;
    endfunction

    function automatic int ptr_w(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/wdata_order_fifo.sv
// Generic DEPTH x entry_t register FIFO with wrapping pointers and an occupancy count.
// Pushes while full and pops while empty are ignored.
module wdata_order_fifo
    import wdata_order_queue_pkg::*;
#(
    parameter int  DEPTH   = 4,
    parameter type entry_t = logic [7:0],
    localparam int PTR_W   = ptr_w(DEPTH)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           push_i,
    input  logic           pop_i,
    input  entry_t         wdata_i,
    output entry_t         rdata_o,
    output logic [PTR_W:0] count_o,
    output logic           full_o,
    output logic           empty_o
);

    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

    entry_t             mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]     count_q,  count_d;
    logic               do_push, do_pop;

    assign full_o  = (count_q == FULL_CNT);
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    // NOTE: every next-state signal takes its hold value first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is deliberately not reset; stale contents are never visible because the head is qualified by count.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/wdata_order_queue.sv
// Write-data ordering queue: records granted AW transactions in order, routes W to the
// oldest one, retires each burst on its beat count and flags WLAST disagreements.
module wdata_order_queue
    import wdata_order_queue_pkg::*;
#(
    parameter int  NUM_MASTERS = 2,
    parameter int  DEPTH       = 4,
    parameter int  LEN_W       = 8,
    parameter int  AFULL_LVL   = DEPTH - 1,
    localparam int ID_W        = id_w(NUM_MASTERS),
    localparam int PTR_W       = ptr_w(DEPTH)
) (
    input  logic             ACLK,
    input  logic             ARESET,
    input  logic             Push_Valid,
    output logic             Push_Ready,
    input  logic [ID_W-1:0]  Push_Master_ID,
    input  logic             Push_Split,
    input  logic [LEN_W-1:0] Push_Len,
    input  logic             W_Beat,
    input  logic             W_Last,
    output logic             Head_Valid,
    output logic [ID_W-1:0]  Head_Master_ID,
    output logic             Head_Split,
    output logic             Head_New_Pulse,
    output logic             Burst_Done,
    output logic [PTR_W:0]   Count,
    output logic             Full,
    output logic             Almost_Full,
    output logic             Last_Error
);

    typedef struct packed {
        logic [ID_W-1:0]  id;
        logic             split;
        logic [LEN_W-1:0] len;
    } entry_t;

    localparam logic [PTR_W:0] AFULL_CNT = (PTR_W+1)'(AFULL_LVL);
    localparam logic [PTR_W:0] ONE_CNT   = (PTR_W+1)'(1);

    entry_t           push_entry, head;
    logic             fifo_full, fifo_empty;
    logic [PTR_W:0]   count;
    logic             push, counted, last_beat, done;
    logic [LEN_W-1:0] beat_cnt_q, beat_cnt_d;
    logic             last_error_q, last_error_d;
    logic             head_new_q, head_new_d;

    assign push_entry = '{id: Push_Master_ID, split: Push_Split, len: Push_Len};

    wdata_order_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (entry_t)
    ) u_fifo (
        .clk     (ACLK),
        .rst     (ARESET),
        .push_i  (push),
        .pop_i   (done),
        .wdata_i (push_entry),
        .rdata_o (head),
        .count_o (count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign Push_Ready = ~fifo_full;
    assign push       = Push_Valid & Push_Ready;

    assign Head_Valid     = ~fifo_empty;
    assign Head_Master_ID = Head_Valid ? head.id : '0;
    assign Head_Split     = Head_Valid & head.split;

    // The beat count, not WLAST, decides when the head burst retires.
    assign counted    = W_Beat & Head_Valid;
    assign last_beat  = (beat_cnt_q == head.len);
    assign done       = counted & last_beat;
    assign Burst_Done = done;

    assign Count       = count;
    assign Full        = fifo_full;
    assign Almost_Full = (count >= AFULL_CNT);
    assign Last_Error  = last_error_q;
    assign Head_New_Pulse = head_new_q;

    always_comb begin
        beat_cnt_d = beat_cnt_q;
        if (done)         beat_cnt_d = '0;
        else if (counted) beat_cnt_d = beat_cnt_q + 1'b1;

        last_error_d = last_error_q | (counted & (W_Last != last_beat));

        // A new head appears when an empty queue fills, or a retiring head leaves a successor behind.
        head_new_d = (push & fifo_empty & ~done)
                   | (done & (count > ONE_CNT))
                   | (done & (count == ONE_CNT) & push);
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            beat_cnt_q   <= '0;
            last_error_q <= 1'b0;
            head_new_q   <= 1'b0;
        end else begin
            beat_cnt_q   <= beat_cnt_d;
            last_error_q <= last_error_d;
            head_new_q   <= head_new_d;
        end
    end

endmodule

// File: tb/tb_wdata_order_queue.sv
// Directed bench for wdata_order_queue: a 2-master/4-deep instance and a 4-master/8-deep one.
// Expected head IDs are queued at push time and checked by per-instance monitors on Head_New_Pulse.
module tb_wdata_order_queue;

    logic       ACLK = 1'b0;
    logic       ARESET;
    logic       pv, sp, wb, wl, sel_b;
    logic [1:0] id;
    logic [7:0] len;

    logic       pr_a, hv_a, hs_a, hnp_a, bd_a, full_a, af_a, le_a;
    logic [0:0] hid_a;
    logic [2:0] cnt_a;
    logic       pr_b, hv_b, hs_b, hnp_b, bd_b, full_b, af_b, le_b;
    logic [1:0] hid_b;
    logic [3:0] cnt_b;

    logic       pr, hv, hs, hnp, bd, full, af, le;
    logic [1:0] hid;
    logic [3:0] cnt;

    typedef struct packed {
        logic [1:0] id;
        logic       split;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];

    int   n_vec = 0;
    int   n_err = 0;
    logic bd_seen;

    always #5 ACLK = ~ACLK;

    wdata_order_queue #(.NUM_MASTERS(2), .DEPTH(4), .LEN_W(8)) u_a (
        .ACLK(ACLK), .ARESET(ARESET),
        .Push_Valid(pv & ~sel_b), .Push_Ready(pr_a),
        .Push_Master_ID(id[0]), .Push_Split(sp), .Push_Len(len),
        .W_Beat(wb & ~sel_b), .W_Last(wl),
        .Head_Valid(hv_a), .Head_Master_ID(hid_a), .Head_Split(hs_a),
        .Head_New_Pulse(hnp_a), .Burst_Done(bd_a), .Count(cnt_a),
        .Full(full_a), .Almost_Full(af_a), .Last_Error(le_a)
    );

    wdata_order_queue #(.NUM_MASTERS(4), .DEPTH(8), .LEN_W(8), .AFULL_LVL(7)) u_b (
        .ACLK(ACLK), .ARESET(ARESET),
        .Push_Valid(pv & sel_b), .Push_Ready(pr_b),
        .Push_Master_ID(id), .Push_Split(sp), .Push_Len(len),
        .W_Beat(wb & sel_b), .W_Last(wl),
        .Head_Valid(hv_b), .Head_Master_ID(hid_b), .Head_Split(hs_b),
        .Head_New_Pulse(hnp_b), .Burst_Done(bd_b), .Count(cnt_b),
        .Full(full_b), .Almost_Full(af_b), .Last_Error(le_b)
    );

    assign pr   = sel_b ? pr_b   : pr_a;
    assign hv   = sel_b ? hv_b   : hv_a;
    assign hs   = sel_b ? hs_b   : hs_a;
    assign hnp  = sel_b ? hnp_b  : hnp_a;
    assign bd   = sel_b ? bd_b   : bd_a;
    assign full = sel_b ? full_b : full_a;
    assign af   = sel_b ? af_b   : af_a;
    assign le   = sel_b ? le_b   : le_a;
    assign hid  = sel_b ? hid_b  : {1'b0, hid_a};
    assign cnt  = sel_b ? cnt_b  : {1'b0, cnt_a};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitors: every head-change pulse must match the oldest outstanding push.
    always @(negedge ACLK) begin
        if (hnp_a) begin
            if (q_a.size() == 0) check("head_a_unexpected_pulse", 32'd1, 32'd0);
            else begin
                exp_t e;
                e = q_a.pop_front();
                check("head_a_valid", hv_a, 1'b1);
                check("head_a_id", hid_a, e.id);
                check("head_a_split", hs_a, e.split);
            end
        end
    end

    always @(negedge ACLK) begin
        if (hnp_b) begin
            if (q_b.size() == 0) check("head_b_unexpected_pulse", 32'd1, 32'd0);
            else begin
                exp_t e;
                e = q_b.pop_front();
                check("head_b_valid", hv_b, 1'b1);
                check("head_b_id", hid_b, e.id);
                check("head_b_split", hs_b, e.split);
            end
        end
    end

    // One clock of stimulus; Burst_Done is captured before the edge since it is combinational.
    task automatic cyc(input logic v, input logic [1:0] i, input logic s, input logic [7:0] l,
                       input logic b, input logic last);
        pv = v; id = i; sp = s; len = l; wb = b; wl = last;
        #2;
        bd_seen = bd;
        @(posedge ACLK);
        #1;
        pv = 1'b0; wb = 1'b0; wl = 1'b0; sp = 1'b0; id = '0; len = '0;
    endtask

    task automatic push(input logic [1:0] i, input logic s, input logic [7:0] l, input logic accept);
        if (accept) begin
            if (sel_b) q_b.push_back('{id: i, split: s});
            else       q_a.push_back('{id: i, split: s});
        end
        cyc(1'b1, i, s, l, 1'b0, 1'b0);
    endtask

    task automatic beat(input logic last);
        cyc(1'b0, 2'd0, 1'b0, 8'd0, 1'b1, last);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        ARESET = 1'b1; sel_b = 1'b0;
        pv = 1'b0; sp = 1'b0; wb = 1'b0; wl = 1'b0; id = '0; len = '0;
        repeat (2) @(posedge ACLK);
        #1;
        ARESET = 1'b0;

        // 1. Reset state, then a single-beat burst.
        check("rst_count", cnt, 0);
        check("rst_head_valid", hv, 0);
        check("rst_push_ready", pr, 1);
        check("rst_full", full, 0);
        check("rst_afull", af, 0);
        check("rst_last_err", le, 0);
        check("rst_pulse", hnp, 0);
        check("rst_head_id", hid, 0);
        check("rst_done", bd, 0);
        push(2'd1, 1'b0, 8'd0, 1'b1);
        check("t1_head_valid", hv, 1);
        check("t1_pulse", hnp, 1);
        check("t1_count", cnt, 1);
        beat(1'b1);
        check("t1_done", bd_seen, 1);
        check("t1_count_after", cnt, 0);
        check("t1_last_err", le, 0);
        check("t1_no_pulse", hnp, 0);

        // 2. Four len=3 bursts, overflow push dropped, 16 beats.
        push(2'd0, 1'b0, 8'd3, 1'b1);
        push(2'd1, 1'b0, 8'd3, 1'b1);
        push(2'd0, 1'b0, 8'd3, 1'b1);
        check("t2_afull_at_3", af, 1);
        check("t2_not_full_at_3", full, 0);
        push(2'd1, 1'b0, 8'd3, 1'b1);
        check("t2_full", full, 1);
        check("t2_ready_low", pr, 0);
        push(2'd1, 1'b1, 8'd0, 1'b0);
        check("t2_drop_count", cnt, 4);
        for (int b = 0; b < 16; b++) begin
            beat((b % 4) == 3);
            check("t2_done", bd_seen, (b % 4) == 3);
        end
        check("t2_count_after", cnt, 0);
        check("t2_last_err", le, 0);

        // 3. Push and retire in the same cycle with Count==2.
        push(2'd0, 1'b0, 8'd0, 1'b1);
        push(2'd1, 1'b0, 8'd1, 1'b1);
        check("t3_count2", cnt, 2);
        check("t3_head0", hid, 0);
        q_a.push_back('{id: 2'd1, split: 1'b1});
        cyc(1'b1, 2'd1, 1'b1, 8'd0, 1'b1, 1'b1);
        check("t3_done", bd_seen, 1);
        check("t3_count_held", cnt, 2);
        check("t3_new_head", hid, 1);
        check("t3_pulse", hnp, 1);
        beat(1'b0);
        check("t3_pulse_one_cycle", hnp, 0);
        check("t3_no_done_mid", bd_seen, 0);
        beat(1'b1);
        check("t3_done2", bd_seen, 1);
        check("t3_split_head", hs, 1);
        beat(1'b1);
        check("t3_done3", bd_seen, 1);
        check("t3_count0", cnt, 0);

        // 4. Early WLAST on beat 2, missing WLAST on beat 4.
        push(2'd0, 1'b0, 8'd3, 1'b1);
        beat(1'b0);
        beat(1'b1);
        check("t4_err_set", le, 1);
        check("t4_no_early_done", bd_seen, 0);
        beat(1'b0);
        check("t4_no_done_b3", bd_seen, 0);
        beat(1'b0);
        check("t4_done_b4", bd_seen, 1);
        check("t4_err_sticky", le, 1);
        check("t4_count0", cnt, 0);

        // 5. Reset mid-burst with Count=3.
        push(2'd1, 1'b0, 8'd3, 1'b1);
        push(2'd0, 1'b0, 8'd3, 1'b1);
        push(2'd1, 1'b0, 8'd3, 1'b1);
        beat(1'b0);
        beat(1'b0);
        check("t5_count3", cnt, 3);
        ARESET = 1'b1;
        q_a.delete();
        cyc(1'b0, 2'd0, 1'b0, 8'd0, 1'b0, 1'b0);
        ARESET = 1'b0;
        check("t5_count", cnt, 0);
        check("t5_head_valid", hv, 0);
        check("t5_ready", pr, 1);
        check("t5_last_err", le, 0);
        check("t5_pulse", hnp, 0);
        push(2'd0, 1'b0, 8'd1, 1'b1);
        beat(1'b0);
        check("t5_fresh_b1", bd_seen, 0);
        beat(1'b1);
        check("t5_fresh_b2", bd_seen, 1);
        check("t5_no_err", le, 0);
        check("t5_count_after", cnt, 0);

        // 6. DEPTH=8, 4 masters: order across the pointer wrap, Almost_Full at 7.
        sel_b = 1'b1;
        push(2'd0, 1'b0, 8'd0, 1'b1);
        push(2'd1, 1'b0, 8'd0, 1'b1);
        push(2'd2, 1'b0, 8'd0, 1'b1);
        push(2'd3, 1'b0, 8'd0, 1'b1);
        push(2'd0, 1'b1, 8'd0, 1'b1);
        push(2'd1, 1'b0, 8'd0, 1'b1);
        check("t6_count6", cnt, 6);
        check("t6_afull_6", af, 0);
        for (int k = 0; k < 3; k++) begin
            beat(1'b1);
            check("t6_pop_done", bd_seen, 1);
        end
        check("t6_count3", cnt, 3);
        push(2'd2, 1'b0, 8'd0, 1'b1);
        push(2'd3, 1'b1, 8'd0, 1'b1);
        push(2'd1, 1'b0, 8'd0, 1'b1);
        push(2'd0, 1'b0, 8'd0, 1'b1);
        check("t6_count7", cnt, 7);
        check("t6_afull_7", af, 1);
        check("t6_not_full_7", full, 0);
        check("t6_ready_7", pr, 1);
        push(2'd2, 1'b1, 8'd0, 1'b1);
        check("t6_full", full, 1);
        check("t6_ready_low", pr, 0);
        for (int k = 0; k < 8; k++) begin
            beat(1'b1);
            check("t6_drain_done", bd_seen, 1);
        end
        check("t6_count0", cnt, 0);
        check("t6_last_err", le, 0);

        repeat (2) @(posedge ACLK);
        #1;
        check("sb_a_drained", q_a.size(), 0);
        check("sb_b_drained", q_b.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
